// File: rtl/microwave_controller.sv
// Microwave sequencing FSM: keypad capture into the timer, start/pause/clear, door gating, timed beep.
// Registered state/strobes (1-cycle latency); mag_on and timer_enable are combinational on door/clear.
module microwave_controller #(
  parameter int unsigned BEEP_SECS = 3
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic       sec_tick,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  input  logic       timer_done,
  output logic [3:0] timer_digit,
  output logic       timer_loadn,
  output logic       timer_clearn,
  output logic       timer_enable,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_COOKING = 3'd2,
    S_PAUSED  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [3:0] BEEP_LAST = 4'(BEEP_SECS);

  state_t     state_q, state_d;
  logic [1:0] count_q, count_d;
  logic [3:0] beep_cnt_q, beep_cnt_d;
  logic [3:0] digit_q, digit_d;
  logic       loadn_q, loadn_d;
  logic       clearn_q, clearn_d;
  logic       beep_q;
  logic       key_ok;

  assign key_ok = key_valid && (key_digit <= 4'd9) && (count_q != 2'd3);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    beep_cnt_d = beep_cnt_q;
    digit_d    = digit_q;
    loadn_d    = 1'b1;
    clearn_d   = 1'b1;
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (stop_clear) begin
          clearn_d = 1'b0;
          state_d  = S_IDLE;
          count_d  = 2'd0;
        end else if (start) begin
          if (state_q == S_ENTRY && door_closed && !timer_done) state_d = S_COOKING;
        end else if (key_ok) begin
          digit_d = key_digit;
          loadn_d = 1'b0;
          count_d = count_q + 2'd1;
          state_d = S_ENTRY;
        end
      end
      S_COOKING: begin
        if (!door_closed || stop_clear) state_d = S_PAUSED;
        else if (timer_done)            state_d = S_DONE;
      end
      S_PAUSED: begin
        if (stop_clear) begin
          clearn_d = 1'b0;
          state_d  = S_IDLE;
          count_d  = 2'd0;
        end else if (start && door_closed) begin
          state_d = S_COOKING;
        end
      end
      S_DONE: begin
        if (start || stop_clear || !door_closed) begin
          state_d = S_IDLE;
          count_d = 2'd0;
        end else if (sec_tick) begin
          beep_cnt_d = beep_cnt_q + 4'd1;
          if (beep_cnt_d == BEEP_LAST) begin
            state_d = S_IDLE;
            count_d = 2'd0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = 2'd0;
      end
    endcase
    // Beep counter only lives in DONE, so every entry starts from zero.
    if (state_d != S_DONE) beep_cnt_d = 4'd0;
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      state_q    <= S_IDLE;
      count_q    <= 2'd0;
      beep_cnt_q <= 4'd0;
      digit_q    <= 4'd0;
      loadn_q    <= 1'b1;
      clearn_q   <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      beep_cnt_q <= beep_cnt_d;
      digit_q    <= digit_d;
      loadn_q    <= loadn_d;
      clearn_q   <= clearn_d;
      beep_q     <= (state_d == S_DONE);
    end
  end

  // Gated by clear so a reset mid-cook cuts the magnetron without waiting for the edge.
  assign mag_on       = (state_q == S_COOKING) && door_closed && !clear;
  assign timer_enable = mag_on && sec_tick && !timer_done;

  assign timer_digit  = digit_q;
  assign timer_loadn  = loadn_q;
  assign timer_clearn = clearn_q;
  assign beep         = beep_q;
  assign state        = state_q;

endmodule

// File: tb/tb_microwave_controller.sv
// Scoreboarded bench for microwave_controller: a behavioural timer plus a rule-level reference model.
module tb_microwave_controller;

  localparam int BEEP = 3;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;

  logic       CLK = 1'b0;
  logic       clear, sec_tick, key_valid, start, stop_clear, door_closed, timer_done;
  logic [3:0] key_digit, timer_digit;
  logic       timer_loadn, timer_clearn, timer_enable, mag_on, beep;
  logic [2:0] state;

  microwave_controller #(.BEEP_SECS(BEEP)) dut (
    .CLK(CLK), .clear(clear), .sec_tick(sec_tick), .key_valid(key_valid),
    .key_digit(key_digit), .start(start), .stop_clear(stop_clear),
    .door_closed(door_closed), .timer_done(timer_done), .timer_digit(timer_digit),
    .timer_loadn(timer_loadn), .timer_clearn(timer_clearn), .timer_enable(timer_enable),
    .mag_on(mag_on), .beep(beep), .state(state)
  );

  always #5 CLK = ~CLK;

  // Timer datapath stand-in: minutes / tens-of-seconds / seconds digits.
  int tm = 0, tt = 0, ts = 0;
  assign timer_done = (tm == 0 && tt == 0 && ts == 0);
  always @(posedge CLK) begin
    if (!timer_clearn) begin
      tm <= 0; tt <= 0; ts <= 0;
    end else if (!timer_loadn) begin
      tm <= tt; tt <= ts; ts <= int'(timer_digit);
    end else if (timer_enable) begin
      if (ts != 0) ts <= ts - 1;
      else if (tt != 0) begin tt <= tt - 1; ts <= 9; end
      else if (tm != 0) begin tm <= tm - 1; tt <= 5; ts <= 9; end
    end
  end

  typedef struct { int cyc; int dig; } load_t;
  typedef struct { int cyc; int st; int bp; } st_t;
  load_t load_q[$];
  int    clr_q[$];
  st_t   st_q[$];

  int checks = 0, passes = 0;
  int n = 0, mcnt = 0;
  int m_mode = M_IDLE;
  int m_keys[$];
  int m_beep_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got %0d, expected %0d", name, mcnt, act, exp);
  endtask

  function automatic int timer_val();
    return tm * 100 + tt * 10 + ts;
  endfunction

  task automatic go_idle(input bit pulse);
    if (pulse) clr_q.push_back(n);
    m_mode = M_IDLE;
    m_keys.delete();
  endtask

  // Reference rules, applied in priority order to the inputs sampled at edge n.
  task automatic model_step(input bit clr, sc, st, kv, input bit [3:0] kd,
                            input bit door, td, tick);
    if (clr) go_idle(1'b1);
    else if (m_mode == M_IDLE || m_mode == M_ENTRY) begin
      if (sc) go_idle(1'b1);
      else if (st) begin
        if (m_mode == M_ENTRY && door && !td) m_mode = M_COOK;
      end else if (kv && kd < 10 && m_keys.size() < 3) begin
        m_keys.push_back(int'(kd));
        load_q.push_back('{n, int'(kd)});
        m_mode = M_ENTRY;
      end
    end else if (m_mode == M_COOK) begin
      if (!door || sc) m_mode = M_PAUSE;
      else if (td) begin m_mode = M_DONE; m_beep_left = BEEP; end
    end else if (m_mode == M_PAUSE) begin
      if (sc) go_idle(1'b1);
      else if (st && door) m_mode = M_COOK;
    end else begin
      if (st || sc || !door) go_idle(1'b0);
      else if (tick) begin
        m_beep_left--;
        if (m_beep_left == 0) go_idle(1'b0);
      end
    end
    st_q.push_back('{n, m_mode, (m_mode == M_DONE) ? 1 : 0});
  endtask

  task automatic cyc(input bit clr, sc, st, kv, input bit [3:0] kd, input bit door, tick);
    bit td;
    clear = clr; stop_clear = sc; start = st; key_valid = kv;
    key_digit = kd; door_closed = door; sec_tick = tick;
    td = timer_done;
    @(posedge CLK);
    #1;
    n++;
    model_step(clr, sc, st, kv, kd, door, td, tick);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 4'd0, 1, 0);
  endtask

  task automatic key(input bit [3:0] d);
    cyc(0, 0, 0, 1, d, 1, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or a new cycle result.
  initial begin
    st_t   se;
    load_t le;
    bit    exp_ld, exp_cl;
    forever begin
      @(negedge CLK);
      mcnt++;
      chk("state_slot", (st_q.size() > 0) ? st_q[0].cyc : -1, mcnt);
      if (st_q.size() > 0 && st_q[0].cyc == mcnt) begin
        se = st_q.pop_front();
        chk("state", 32'(state), se.st);
        chk("beep", 32'(beep), se.bp);
      end
      exp_ld = (load_q.size() > 0 && load_q[0].cyc == mcnt);
      if (exp_ld || timer_loadn !== 1'b1) begin
        chk("loadn", 32'(timer_loadn), exp_ld ? 0 : 1);
        if (exp_ld) begin
          le = load_q.pop_front();
          chk("digit", 32'(timer_digit), le.dig);
        end
      end
      exp_cl = (clr_q.size() > 0 && clr_q[0] == mcnt);
      if (exp_cl || timer_clearn !== 1'b1) begin
        chk("clearn", 32'(timer_clearn), exp_cl ? 0 : 1);
        if (exp_cl) void'(clr_q.pop_front());
      end
      chk("mag_on", 32'(mag_on), (m_mode == M_COOK && door_closed && !clear) ? 1 : 0);
      chk("timer_enable", 32'(timer_enable),
          (m_mode == M_COOK && door_closed && sec_tick && !timer_done && !clear) ? 1 : 0);
    end
  end

  initial begin
    bit door, sc, st, kv, tick, clr;
    bit [3:0] kd;
    int r;
    #1;
    cyc(1, 0, 0, 0, 4'd0, 1, 0);
    cyc(1, 0, 0, 0, 4'd0, 1, 0);
    idle(2);
    key(4'd1); key(4'd3); key(4'd0); key(4'd5); key(4'd12);
    idle(1);
    chk("timer_1_30", timer_val(), 130);
    cyc(0, 0, 1, 0, 4'd0, 1, 0);
    cyc(0, 0, 0, 0, 4'd0, 1, 1);
    cyc(0, 0, 0, 0, 4'd0, 1, 1);
    cyc(0, 0, 0, 0, 4'd0, 0, 1);
    cyc(0, 0, 0, 0, 4'd0, 0, 1);
    chk("timer_hold", timer_val(), 128);
    cyc(0, 0, 1, 0, 4'd0, 1, 0);
    cyc(0, 0, 0, 0, 4'd0, 1, 1);
    chk("timer_resume", timer_val(), 127);
    cyc(0, 1, 0, 0, 4'd0, 1, 0);
    cyc(0, 1, 1, 0, 4'd0, 1, 0);
    idle(1);
    chk("timer_cleared", timer_val(), 0);
    cyc(0, 0, 1, 0, 4'd0, 1, 0);
    key(4'd0);
    idle(1);
    cyc(0, 0, 1, 0, 4'd0, 1, 0);
    cyc(0, 1, 0, 0, 4'd0, 1, 0);
    key(4'd3);
    idle(1);
    cyc(0, 0, 1, 0, 4'd0, 1, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 4'd0, 1, i[0]);
    key(4'd5);
    idle(1);
    cyc(0, 0, 1, 0, 4'd0, 1, 0);
    idle(2);
    cyc(1, 0, 0, 0, 4'd0, 1, 1);
    idle(2);

    door = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 39) == 0) door = ~door;
      clr  = ($urandom_range(0, 499) == 0);
      sc   = ($urandom_range(0, 59) == 0);
      st   = ($urandom_range(0, 7) == 0);
      kv   = ($urandom_range(0, 3) == 0);
      tick = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      if (r < 6)      kd = 4'($urandom_range(0, 2));
      else if (r < 9) kd = 4'($urandom_range(0, 9));
      else            kd = 4'($urandom_range(10, 15));
      cyc(clr, sc, st, kv, kd, door, tick);
    end
    idle(1);
    @(negedge CLK);
    #1;
    chk("load_left", load_q.size(), 0);
    chk("clear_left", clr_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
